// File: rtl/rf_alu_ctrl.sv
// Multicycle sequencer for the RFplusALU datapath and the shared instruction/data memory port.
// state  | meaning
// FETCH  | read instruction at PC, wait on mem_ready
// DECODE | drive ID controls from IR
// EXE    | drive ALU controls, capture PSW, resolve branches
// MEM    | data access at Rm, wait on mem_ready
// WB     | register-file write back
// HALT   | parked until reset
module rf_alu_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [15:0] Instr,
    input  logic        mem_ready,
    input  logic        C,
    input  logic        Z,
    input  logic        N,
    output logic [10:0] Ins,
    output logic        WBRF,
    output logic        WBresource,
    output logic        RBresource,
    output logic        OprandB,
    output logic        LI,
    output logic        Buff_IDEXE,
    output logic        ALUop,
    output logic        Flag,
    output logic        PSW_C,
    output logic        WBDataSel,
    output logic        MemReq,
    output logic        MemWE,
    output logic        MemAddrSel,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        Halted,
    output logic        MemErr
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [2:0]        psw_q, psw_d;
    logic [TO_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic              err_q, err_d;
    logic              run_q;
    logic              wait_hit, waiting;
    logic              unused_psw_n;

    logic [4:0] op;
    logic is_add, is_adc, is_sub, is_sbc, is_cmp, is_lhi, is_lli;
    logic is_ldr, is_str, is_b, is_beq, is_hlt, is_alu, is_nop;

    assign op     = ir_q[15:11];
    assign is_add = (op == 5'b00001);
    assign is_adc = (op == 5'b00010);
    assign is_sub = (op == 5'b00011);
    assign is_sbc = (op == 5'b00100);
    assign is_cmp = (op == 5'b00101);
    assign is_lhi = (op == 5'b01000);
    assign is_lli = (op == 5'b01001);
    assign is_ldr = (op == 5'b10000);
    assign is_str = (op == 5'b10001);
    assign is_b   = (op == 5'b11000);
    assign is_beq = (op == 5'b11001);
    assign is_hlt = (op == 5'b11111);
    assign is_alu = is_add | is_adc | is_sub | is_sbc;
    // Undefined opcodes fall into the NOP path.
    assign is_nop = ~(is_alu | is_cmp | is_lhi | is_lli | is_ldr | is_str
                      | is_b | is_beq | is_hlt);

    // N is kept in the PSW for completeness but nothing downstream consumes it.
    assign unused_psw_n = psw_q[0];

    assign cnt_inc  = cnt_q + 1'b1;
    assign wait_hit = (MEM_TIMEOUT != 0) && (cnt_inc == TO_W'(MEM_TIMEOUT));
    assign waiting  = run_q && !mem_ready && (state_q == S_FETCH || state_q == S_MEM);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        psw_d   = psw_q;
        err_d   = err_q;
        case (state_q)
            S_FETCH: begin
                if (run_q) begin
                    if (mem_ready) begin
                        ir_d    = Instr;
                        state_d = S_DECODE;
                    end else if (wait_hit) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                end
            end
            S_DECODE: begin
                if (is_nop)      state_d = S_FETCH;
                else if (is_hlt) state_d = S_HALT;
                else             state_d = S_EXE;
            end
            S_EXE: begin
                if (is_alu || is_cmp) psw_d = {C, Z, N};
                if (is_alu || is_lhi || is_lli) state_d = S_WB;
                else if (is_ldr || is_str)      state_d = S_MEM;
                else                            state_d = S_FETCH;
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = is_ldr ? S_WB : S_FETCH;
                end else if (wait_hit) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        // The counter restarts whenever the state changes.
        cnt_d = (waiting && state_d == state_q) ? cnt_inc : '0;
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            psw_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            psw_q   <= psw_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            run_q   <= 1'b1;
        end
    end

    // run_q holds every output low for the cycle following any reset edge.
    always_comb begin
        Ins        = '0;
        WBRF       = 1'b0;
        WBresource = 1'b0;
        RBresource = 1'b0;
        OprandB    = 1'b0;
        LI         = 1'b0;
        Buff_IDEXE = 1'b0;
        ALUop      = 1'b0;
        Flag       = 1'b0;
        PSW_C      = 1'b0;
        WBDataSel  = 1'b0;
        MemReq     = 1'b0;
        MemWE      = 1'b0;
        MemAddrSel = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        Halted     = 1'b0;
        MemErr     = 1'b0;
        if (run_q) begin
            Ins    = ir_q[10:0];
            PSW_C  = psw_q[2];
            MemErr = err_q;
            case (state_q)
                S_FETCH: begin
                    MemReq  = 1'b1;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    Buff_IDEXE = ~is_nop;
                    RBresource = is_lhi;
                    LI         = is_lhi;
                end
                S_EXE: begin
                    ALUop   = is_sub | is_sbc | is_cmp;
                    Flag    = is_adc | is_sbc;
                    PCWrite = is_b | (is_beq & psw_q[1]);
                    PCSrc   = is_b | is_beq;
                end
                S_MEM: begin
                    MemReq     = 1'b1;
                    MemAddrSel = 1'b1;
                    MemWE      = is_str;
                end
                S_WB: begin
                    WBRF       = 1'b1;
                    WBresource = is_ldr;
                    WBDataSel  = is_lhi | is_lli;
                end
                S_HALT:  Halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_alu_ctrl.sv
// Directed bench for rf_alu_ctrl: per-cycle expected output vectors go through a scoreboard queue.
module tb_rf_alu_ctrl;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] Instr = '0;
    logic        mem_ready = 1'b0;
    logic        C = 1'b0, Z = 1'b0, N = 1'b0;
    logic [10:0] Ins;
    logic WBRF, WBresource, RBresource, OprandB, LI, Buff_IDEXE;
    logic ALUop, Flag, PSW_C, WBDataSel, MemReq, MemWE, MemAddrSel;
    logic PCWrite, PCSrc, Halted, MemErr;

    rf_alu_ctrl #(.MEM_TIMEOUT(15), .TO_W(4)) dut (
        .clk(clk), .Reset(Reset), .Instr(Instr), .mem_ready(mem_ready),
        .C(C), .Z(Z), .N(N), .Ins(Ins),
        .WBRF(WBRF), .WBresource(WBresource), .RBresource(RBresource),
        .OprandB(OprandB), .LI(LI), .Buff_IDEXE(Buff_IDEXE),
        .ALUop(ALUop), .Flag(Flag), .PSW_C(PSW_C), .WBDataSel(WBDataSel),
        .MemReq(MemReq), .MemWE(MemWE), .MemAddrSel(MemAddrSel),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .Halted(Halted), .MemErr(MemErr)
    );

    always #5 clk = ~clk;

    localparam logic [16:0] K_WBRF  = 17'd1 << 16;
    localparam logic [16:0] K_WBRES = 17'd1 << 15;
    localparam logic [16:0] K_RBRES = 17'd1 << 14;
    localparam logic [16:0] K_LI    = 17'd1 << 12;
    localparam logic [16:0] K_BUF   = 17'd1 << 11;
    localparam logic [16:0] K_ALUOP = 17'd1 << 10;
    localparam logic [16:0] K_FLAG  = 17'd1 << 9;
    localparam logic [16:0] K_PSWC  = 17'd1 << 8;
    localparam logic [16:0] K_WBDS  = 17'd1 << 7;
    localparam logic [16:0] K_MREQ  = 17'd1 << 6;
    localparam logic [16:0] K_MWE   = 17'd1 << 5;
    localparam logic [16:0] K_MAS   = 17'd1 << 4;
    localparam logic [16:0] K_PCW   = 17'd1 << 3;
    localparam logic [16:0] K_PCS   = 17'd1 << 2;
    localparam logic [16:0] K_HALT  = 17'd1 << 1;
    localparam logic [16:0] K_ERR   = 17'd1;

    logic [27:0] obs;
    assign obs = {Ins, WBRF, WBresource, RBresource, OprandB, LI, Buff_IDEXE,
                  ALUop, Flag, PSW_C, WBDataSel, MemReq, MemWE, MemAddrSel,
                  PCWrite, PCSrc, Halted, MemErr};

    typedef struct {
        string       tag;
        logic [27:0] exp;
    } sb_t;
    sb_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] ir_m = '0;
    logic        pswc_m = 1'b0;

    // One clock cycle: drive inputs, queue the expectation, compare at the falling edge.
    task automatic cyc(input string tag, input logic rdy, input logic [2:0] czn,
                       input logic [16:0] ctrl);
        sb_t e;
        mem_ready = rdy;
        {C, Z, N} = czn;
        sb.push_back('{tag, {ir_m[10:0], ctrl | (pswc_m ? K_PSWC : 17'd0)}});
        @(negedge clk);
        e = sb.pop_front();
        n_tests++;
        assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [15:0] instr, input int waits);
        Instr = instr;
        for (int i = 0; i < waits; i++) cyc(tag, 1'b0, 3'b000, K_MREQ);
        cyc(tag, 1'b1, 3'b000, K_MREQ | K_PCW);
        ir_m = instr;
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b0;
        mem_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        ir_m = '0;
        pswc_m = 1'b0;
        cyc("rst_hold", 1'b0, 3'b000, 17'd0);
        Reset = 1'b1;
        cyc("rst_idle", 1'b1, 3'b000, 17'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);

        fetch("add_f", 16'h0A24, 0);
        cyc("add_d", 1'b0, 3'b000, K_BUF);
        cyc("add_e", 1'b0, 3'b100, 17'd0);
        pswc_m = 1'b1;
        cyc("add_wb", 1'b0, 3'b000, K_WBRF);

        fetch("adc_f", 16'h1224, 0);
        cyc("adc_d", 1'b0, 3'b000, K_BUF);
        cyc("adc_e", 1'b0, 3'b000, K_FLAG);
        pswc_m = 1'b0;
        cyc("adc_wb", 1'b0, 3'b000, K_WBRF);

        fetch("ldr_f", 16'h8380, 2);
        cyc("ldr_d", 1'b0, 3'b000, K_BUF);
        cyc("ldr_e", 1'b0, 3'b111, 17'd0);
        for (int i = 0; i < 3; i++) cyc("ldr_mem_wait", 1'b0, 3'b000, K_MREQ | K_MAS);
        cyc("ldr_mem", 1'b1, 3'b000, K_MREQ | K_MAS);
        cyc("ldr_wb", 1'b0, 3'b000, K_WBRF | K_WBRES);

        fetch("str_f", 16'h8880, 0);
        cyc("str_d", 1'b0, 3'b000, K_BUF);
        cyc("str_e", 1'b0, 3'b000, 17'd0);
        cyc("str_mem", 1'b1, 3'b000, K_MREQ | K_MAS | K_MWE);

        fetch("cmp1_f", 16'h2824, 0);
        cyc("cmp1_d", 1'b0, 3'b000, K_BUF);
        cyc("cmp1_e", 1'b0, 3'b010, K_ALUOP);
        fetch("beq_t_f", 16'hC800, 0);
        cyc("beq_t_d", 1'b0, 3'b000, K_BUF);
        cyc("beq_t_e", 1'b1, 3'b000, K_PCW | K_PCS);

        fetch("cmp0_f", 16'h2824, 0);
        cyc("cmp0_d", 1'b0, 3'b000, K_BUF);
        cyc("cmp0_e", 1'b0, 3'b000, K_ALUOP);
        fetch("beq_n_f", 16'hC800, 0);
        cyc("beq_n_d", 1'b0, 3'b000, K_BUF);
        cyc("beq_n_e", 1'b0, 3'b010, K_PCS);

        fetch("b_f", 16'hC000, 0);
        cyc("b_d", 1'b0, 3'b000, K_BUF);
        cyc("b_e", 1'b0, 3'b000, K_PCW | K_PCS);

        fetch("lhi_f", 16'h41AB, 0);
        cyc("lhi_d", 1'b0, 3'b000, K_BUF | K_RBRES | K_LI);
        cyc("lhi_e", 1'b0, 3'b100, 17'd0);
        cyc("lhi_wb", 1'b0, 3'b000, K_WBRF | K_WBDS);

        fetch("lli_f", 16'h4855, 0);
        cyc("lli_d", 1'b0, 3'b000, K_BUF);
        cyc("lli_e", 1'b0, 3'b000, 17'd0);
        cyc("lli_wb", 1'b0, 3'b000, K_WBRF | K_WBDS);

        fetch("sub_f", 16'h1A24, 0);
        cyc("sub_d", 1'b0, 3'b000, K_BUF);
        cyc("sub_e", 1'b0, 3'b001, K_ALUOP);
        cyc("sub_wb", 1'b0, 3'b000, K_WBRF);

        fetch("sbc_f", 16'h2224, 0);
        cyc("sbc_d", 1'b0, 3'b000, K_BUF);
        cyc("sbc_e", 1'b0, 3'b100, K_ALUOP | K_FLAG);
        pswc_m = 1'b1;
        cyc("sbc_wb", 1'b0, 3'b000, K_WBRF);

        fetch("nop_f", 16'h0000, 0);
        cyc("nop_d", 1'b1, 3'b000, 17'd0);
        fetch("undef_f", 16'h3000, 0);
        cyc("undef_d", 1'b0, 3'b000, 17'd0);

        fetch("to_edge_f", 16'h0000, 14);
        cyc("to_edge_d", 1'b0, 3'b000, 17'd0);

        fetch("strr_f", 16'h8880, 0);
        cyc("strr_d", 1'b0, 3'b000, K_BUF);
        cyc("strr_e", 1'b0, 3'b000, 17'd0);
        Reset = 1'b0;
        cyc("strr_mem", 1'b0, 3'b000, K_MREQ | K_MAS | K_MWE);
        ir_m = '0;
        pswc_m = 1'b0;
        Reset = 1'b1;
        cyc("strr_post_rst", 1'b1, 3'b000, 17'd0);
        fetch("post_rst_f", 16'h0A24, 0);
        cyc("post_rst_d", 1'b0, 3'b000, K_BUF);
        cyc("post_rst_e", 1'b0, 3'b000, 17'd0);
        cyc("post_rst_wb", 1'b0, 3'b000, K_WBRF);

        fetch("hlt_f", 16'hF8FF, 0);
        cyc("hlt_d", 1'b0, 3'b000, K_BUF);
        for (int i = 0; i < 20; i++) cyc("halted", 1'($urandom_range(1)), 3'b000, K_HALT);

        do_reset(2);
        Instr = 16'h0A24;
        for (int i = 0; i < 15; i++) cyc("to_wait", 1'b0, 3'b000, K_MREQ);
        for (int i = 0; i < 3; i++) cyc("to_halt", 1'b1, 3'b000, K_HALT | K_ERR);
        do_reset(1);
        fetch("after_err_f", 16'h0000, 0);
        cyc("after_err_d", 1'b0, 3'b000, 17'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
